mem_arbiter: RTL and testbench

//  Shares the single main-memory request/response port between the icache (read-only, port I)
//  and the dcache (read/write, port D) inside the memory system. One transaction is in flight
//  at a time. The block round-robin arbitrates, forwards write beats, and routes read beats

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one main-memory port between icache and dcache
//
// Purpose: grants one cache at a time onto the mem_req_*/mem_resp_* port, forwards dcache
// write beats, and routes read beats back to the owner by tag. One transaction in flight.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   ic_req_*             icache line-read request (valid/ready/addr)
//   ic_resp_*            icache read beats (valid/data)
//   dc_req_*             dcache request (valid/ready/rw/addr)
//   dc_data_*            dcache write beats (valid/ready/bits/mask)
//   dc_resp_*            dcache read beats (valid/data)
//   mem_req_*            main-memory request (valid/ready/rw/addr/tag)
//   mem_req_data_*       main-memory write beats (valid/ready/bits/mask)
//   mem_resp_*           main-memory read beats (valid/data/tag), no backpressure
//   tag_err              sticky flag for any unexpected response beat
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 5,
    parameter int BEATS     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    output logic                   ic_resp_valid,
    output logic [DATA_BITS-1:0]   ic_resp_data,
    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic                   dc_req_rw,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_data_valid,
    output logic                   dc_data_ready,
    input  logic [DATA_BITS-1:0]   dc_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_data_mask,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   dc_resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic [TAG_BITS-1:0]    mem_req_tag,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data,
    input  logic [TAG_BITS-1:0]    mem_resp_tag,
    output logic                   tag_err
);

    localparam int   CNT_W = $clog2(BEATS) + 1;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WDATA = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 rw_q, rw_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 rr_last_q, rr_last_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                 tag_err_q, tag_err_d;

    // Ungated versions of the handshake outputs; reset masks them below.
    logic ic_req_ready_c, dc_req_ready_c, mem_req_valid_c, mem_req_data_valid_c;
    logic dc_data_ready_c, ic_resp_valid_c, dc_resp_valid_c;

    logic [TAG_BITS-1:0] exp_tag;
    logic                resp_ok;
    logic                any_req;
    logic                win_d;
    logic                last_beat;

    assign exp_tag   = TAG_BITS'(owner_q);
    assign resp_ok   = mem_resp_valid && (mem_resp_tag == exp_tag);
    assign any_req   = ic_req_valid || dc_req_valid;
    // D wins when it is the only requester, or on a tie when I was granted last.
    assign win_d     = dc_req_valid && (!ic_req_valid || (rr_last_q == OWN_I));
    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_D;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            rr_last_q  <= OWN_I;
            beat_cnt_q <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
            tag_err_q  <= tag_err_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        owner_d              = owner_q;
        rw_d                 = rw_q;
        addr_d               = addr_q;
        rr_last_d            = rr_last_q;
        beat_cnt_d           = beat_cnt_q;
        tag_err_d            = tag_err_q;
        ic_req_ready_c       = 1'b0;
        dc_req_ready_c       = 1'b0;
        mem_req_valid_c      = 1'b0;
        mem_req_data_valid_c = 1'b0;
        dc_data_ready_c      = 1'b0;
        ic_resp_valid_c      = 1'b0;
        dc_resp_valid_c      = 1'b0;

        // Any beat outside RESP has no transaction to belong to.
        if (state_q != S_RESP && mem_resp_valid) begin
            tag_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    ic_req_ready_c = !win_d;
                    dc_req_ready_c = win_d;
                    owner_d        = win_d;
                    rr_last_d      = win_d;
                    rw_d           = win_d ? dc_req_rw : 1'b0;
                    addr_d         = win_d ? dc_req_addr : ic_req_addr;
                    state_d        = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid_c = 1'b1;
                if (mem_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = rw_q ? S_WDATA : S_RESP;
                end
            end
            S_WDATA: begin
                mem_req_data_valid_c = dc_data_valid;
                dc_data_ready_c      = mem_req_data_ready;
                if (dc_data_valid && mem_req_data_ready) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RESP: begin
                if (resp_ok) begin
                    ic_resp_valid_c = (owner_q == OWN_I);
                    dc_resp_valid_c = (owner_q == OWN_D);
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else if (mem_resp_valid) begin
                    tag_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset is a level here too: while it is held low nothing may handshake,
    // even though IDLE would otherwise grant combinationally.
    assign ic_req_ready       = reset & ic_req_ready_c;
    assign dc_req_ready       = reset & dc_req_ready_c;
    assign mem_req_valid      = reset & mem_req_valid_c;
    assign mem_req_data_valid = reset & mem_req_data_valid_c;
    assign dc_data_ready      = reset & dc_data_ready_c;
    assign ic_resp_valid      = reset & ic_resp_valid_c;
    assign dc_resp_valid      = reset & dc_resp_valid_c;

    assign mem_req_rw        = rw_q;
    assign mem_req_addr      = addr_q;
    assign mem_req_tag       = exp_tag;
    assign mem_req_data_bits = dc_data_bits;
    assign mem_req_data_mask = dc_data_mask;
    assign ic_resp_data      = mem_resp_data;
    assign dc_resp_data      = mem_resp_data;
    assign tag_err           = tag_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AB    = 28;
    localparam int DB    = 128;
    localparam int TB    = 5;
    localparam int BEATS = 4;
    localparam int MB    = DB / 8;

    logic          clk;
    logic          reset;
    logic          ic_req_valid, ic_req_ready;
    logic [AB-1:0] ic_req_addr;
    logic          ic_resp_valid;
    logic [DB-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rw;
    logic [AB-1:0] dc_req_addr;
    logic          dc_data_valid, dc_data_ready;
    logic [DB-1:0] dc_data_bits;
    logic [MB-1:0] dc_data_mask;
    logic          dc_resp_valid;
    logic [DB-1:0] dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AB-1:0] mem_req_addr;
    logic [TB-1:0] mem_req_tag;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DB-1:0] mem_req_data_bits;
    logic [MB-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DB-1:0] mem_resp_data;
    logic [TB-1:0] mem_resp_tag;
    logic          tag_err;

    mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr),
        .dc_data_valid(dc_data_valid), .dc_data_ready(dc_data_ready),
        .dc_data_bits(dc_data_bits), .dc_data_mask(dc_data_mask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_tag(mem_resp_tag), .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference state: who was granted last (0=I, 1=D) and the sticky error flag.
    bit rr_last_m;
    bit tag_err_m;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else pass_cnt++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
        dc_data_valid = 0; dc_data_bits = '0; dc_data_mask = '0;
        mem_req_ready = 0; mem_req_data_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0; mem_resp_tag = '0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_all_quiet(input string where);
        check({where, "_ic_rdy"}, ic_req_ready, 0);
        check({where, "_dc_rdy"}, dc_req_ready, 0);
        check({where, "_mreq_v"}, mem_req_valid, 0);
        check({where, "_mdat_v"}, mem_req_data_valid, 0);
        check({where, "_dc_drdy"}, dc_data_ready, 0);
        check({where, "_ic_rv"}, ic_resp_valid, 0);
        check({where, "_dc_rv"}, dc_resp_valid, 0);
        check({where, "_tag_err"}, tag_err, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        ic_req_valid = 1; dc_req_valid = 1; mem_req_ready = 1; mem_req_data_ready = 1;
        reset = 0;
        #2;
        check_all_quiet("rst");
        next_cycle();
        next_cycle();
        idle_inputs();
        reset = 1;
        rr_last_m = 0;
        tag_err_m = 0;
    endtask

    // One arbitration plus the winner's full transaction. The loser keeps its valid high.
    task automatic round(input bit ic_v, input bit dc_v, input bit dc_rw,
                         input logic [AB-1:0] ia, input logic [AB-1:0] da,
                         input int stall, input bit bad_tag, input bit wr_toggle, input int abort_at);
        bit            w;
        bit            rw;
        bit            vld;
        bit            ok;
        bit            bad_done;
        logic [AB-1:0] a;
        logic [TB-1:0] tg;
        logic [DB-1:0] d;
        logic [MB-1:0] m;
        int            good;
        int            cyc;

        w  = (ic_v && dc_v) ? ~rr_last_m : dc_v;
        a  = w ? da : ia;
        rw = w ? dc_rw : 1'b0;

        ic_req_valid = ic_v; ic_req_addr = ia;
        dc_req_valid = dc_v; dc_req_rw = dc_rw; dc_req_addr = da;
        @(negedge clk);
        check("grant_ic", ic_req_ready, ic_v && !w);
        check("grant_dc", dc_req_ready, w);
        check("idle_mreq_v", mem_req_valid, 0);
        check("idle_tag_err", tag_err, tag_err_m);
        next_cycle();
        rr_last_m = w;
        if (w) dc_req_valid = 0;
        else   ic_req_valid = 0;

        // Write-channel probes show that nothing leaks before WDATA.
        dc_data_valid = 1; mem_req_data_ready = 1;
        for (int i = 0; i <= stall; i++) begin
            mem_req_ready = (i == stall);
            @(negedge clk);
            check("req_valid", mem_req_valid, 1);
            check("req_addr", mem_req_addr, a);
            check("req_rw", mem_req_rw, rw);
            check("req_tag", mem_req_tag, {4'b0, w});
            check("req_ic_rdy", ic_req_ready, 0);
            check("req_dc_rdy", dc_req_ready, 0);
            check("req_dc_drdy", dc_data_ready, 0);
            check("req_mdat_v", mem_req_data_valid, 0);
            next_cycle();
        end
        mem_req_ready = 0; dc_data_valid = 0; mem_req_data_ready = 0;

        good = 0;
        cyc  = 0;
        if (rw) begin
            while (good < BEATS && cyc < 200) begin
                d = rand128();
                m = MB'($urandom());
                dc_data_bits  = d;
                dc_data_mask  = m;
                dc_data_valid = wr_toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
                mem_req_data_ready = wr_toggle ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
                @(negedge clk);
                check("wr_valid", mem_req_data_valid, dc_data_valid);
                check("wr_ready", dc_data_ready, mem_req_data_ready);
                check("wr_bits", mem_req_data_bits, d);
                check("wr_mask", mem_req_data_mask, m);
                check("wr_ic_rv", ic_resp_valid, 0);
                check("wr_dc_rv", dc_resp_valid, 0);
                check("wr_ic_rdy", ic_req_ready, 0);
                check("wr_dc_rdy", dc_req_ready, 0);
                if (dc_data_valid && mem_req_data_ready) good++;
                next_cycle();
                cyc++;
            end
            dc_data_valid = 0; mem_req_data_ready = 0;
            check("wr_beats", good, BEATS);
        end else begin
            bad_done = 0;
            while (good < BEATS && cyc < 200) begin
                if (abort_at != 0 && good == abort_at) begin
                    mem_resp_valid = 1; mem_resp_tag = {4'b0, w};
                    ic_req_valid = 1; dc_req_valid = 1;
                    reset = 0;
                    #1;
                    check_all_quiet("abort");
                    @(negedge clk);
                    check_all_quiet("abort_hold");
                    next_cycle();
                    idle_inputs();
                    reset = 1;
                    rr_last_m = 0;
                    tag_err_m = 0;
                    return;
                end
                d = rand128();
                vld = ($urandom_range(0, 3) != 0);
                tg  = {4'b0, w};
                if (bad_tag && !bad_done && good == 1) begin
                    vld = 1;
                    tg  = TB'($urandom_range(0, 31));
                    if (tg == {4'b0, w}) tg = tg ^ 5'd1;
                    bad_done = 1;
                end
                mem_resp_valid = vld; mem_resp_tag = tg; mem_resp_data = d;
                @(negedge clk);
                ok = vld && (tg == {4'b0, w});
                check("rd_ic_rv", ic_resp_valid, ok && !w);
                check("rd_dc_rv", dc_resp_valid, ok && w);
                if (ok && !w) check("rd_ic_data", ic_resp_data, d);
                if (ok && w)  check("rd_dc_data", dc_resp_data, d);
                check("rd_tag_err", tag_err, tag_err_m);
                check("rd_mreq_v", mem_req_valid, 0);
                check("rd_ic_rdy", ic_req_ready, 0);
                check("rd_dc_rdy", dc_req_ready, 0);
                if (ok) good++;
                else if (vld) tag_err_m = 1;
                next_cycle();
                cyc++;
            end
            mem_resp_valid = 0;
            check("rd_beats", good, BEATS);
        end
    endtask

    task automatic idle_beat();
        idle_inputs();
        mem_resp_valid = 1; mem_resp_tag = '0; mem_resp_data = rand128();
        @(negedge clk);
        check("idlebeat_ic_rv", ic_resp_valid, 0);
        check("idlebeat_dc_rv", dc_resp_valid, 0);
        check("idlebeat_err_before", tag_err, tag_err_m);
        tag_err_m = 1;
        next_cycle();
        mem_resp_valid = 0;
        @(negedge clk);
        check("idlebeat_err_after", tag_err, tag_err_m);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 0;
        rr_last_m = 0;
        tag_err_m = 0;
        next_cycle();
        do_reset();

        round(1, 0, 0, 28'h0001234, '0, 0, 0, 0, 0);
        round(0, 1, 1, '0, 28'h00000A0, 0, 0, 1, 0);

        do_reset();
        for (int r = 0; r < 3; r++)
            round(1, 1, 0, AB'($urandom()), AB'($urandom()), 0, 0, 0, 0);

        round(1, 0, 0, 28'h0000040, '0, 0, 1, 0, 0);
        round(1, 0, 0, 28'h0000080, '0, 10, 0, 0, 0);
        idle_beat();

        round(1, 0, 0, 28'h0000100, '0, 0, 0, 0, 2);
        round(1, 0, 0, 28'h0000140, '0, 0, 0, 0, 0);

        for (int r = 0; r < 40; r++) begin
            bit iv;
            bit dv;
            iv = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            if (!iv && !dv) dv = 1;
            round(iv, dv, 1'($urandom_range(0, 1)), AB'($urandom()), AB'($urandom()),
                  $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 0, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
